// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, status flags, control FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_pkg;

    // Opcode encoding seen on encode_op.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SLL = 3'b010,
        OP_SRL = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    // Status flags, packed in the order they appear on the flags port.
    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } alu_flags_t;

    localparam int unsigned FLAG_W = $bits(alu_flags_t);

    // IDLE accepts new ops; BUSY runs the multi-cycle multiply.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per clock.
// Latency: start at edge k, done high in the cycle after edge k+WIDTH-1 (prod valid then).
// Backpressure: none; caller must not pulse start while an op is in flight.
//
// Ports:
//   clk, reset_n  clock and async active-low reset
//   start         load operands and perform the first iteration
//   a, b          multiplicand / multiplier, captured on start
//   done          one-cycle pulse, prod holds the full product while it is high
//   prod          2*WIDTH-bit product
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;

    // The start edge already folds in multiplier bit 0, so WIDTH iterations
    // complete at edge k+WIDTH-1 and the top can register the product at k+WIDTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                r_mplier <= {1'b0, b[WIDTH-1:1]};
                r_cnt    <= CNT_W'(1);
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                if (r_cnt == CNT_W'(WIDTH-1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign done = r_done;
    assign prod = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, status flags and a sequential multiply.
// Latency: single-cycle ops 1 clock (1 op/clk sustained); MUL WIDTH clocks, input stalled meanwhile.
// Backpressure: in_ready drops while MUL runs or while a result is held with out_ready low.
//
// Ports:
//   clk, reset_n          clock and async active-low reset
//   a, b, encode_op       operands and opcode, captured on input accept
//   in_valid / in_ready   input handshake
//   alu_o, flags          registered result and {C,V,N,Z}
//   out_valid / out_ready output handshake
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [2:0]        encode_op,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  alu_o,
    output logic [FLAG_W-1:0] flags,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int SHW = $clog2(WIDTH);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_alu_o;
    alu_flags_t         r_flags;
    logic               r_out_valid;

    alu_op_e            w_op;
    logic [SHW-1:0]     w_sh;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_start;
    logic               w_load_alu;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    alu_flags_t         w_alu_flags;
    logic [WIDTH-1:0]   w_mul_res;
    alu_flags_t         w_mul_flags;
    logic               w_mul_hi;

    assign w_op        = alu_op_e'(encode_op);
    assign w_sh        = b[SHW-1:0];
    assign w_is_mul    = (w_op == OP_MUL);
    // Ready depends only on state and the output slot, never on in_valid.
    assign w_in_ready  = (r_state != BUSY) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_mul_start = w_accept && w_is_mul;
    assign w_load_alu  = w_accept && !w_is_mul;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .prod    (w_prod)
    );

    // Single-cycle datapath; carry comes out of a one-bit-wider computation.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_op)
            OP_ADD: begin
                {w_c, w_res} = {1'b0, a} + {1'b0, b};
                w_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                {w_c, w_res} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                w_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            // The extra bit catches the last bit shifted out; zero for a zero shift.
            OP_SLL:  {w_c, w_res} = {1'b0, a} << w_sh;
            OP_SRL:  {w_res, w_c} = {a, 1'b0} >> w_sh;
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            default: w_res = '0;
        endcase
    end

    assign w_alu_flags = '{c: w_c, v: w_v, n: w_res[WIDTH-1], z: (w_res == '0)};

    assign w_mul_res   = w_prod[WIDTH-1:0];
    assign w_mul_hi    = |w_prod[2*WIDTH-1:WIDTH];
    assign w_mul_flags = '{c: w_mul_hi, v: w_mul_hi, n: w_mul_res[WIDTH-1], z: (w_mul_res == '0)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_mul_start) w_state_nxt = BUSY;
            BUSY:    if (w_mul_done)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output slot: a new result (either source) wins over a same-edge transfer,
    // which is what keeps back-to-back single-cycle ops at one per clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_o     <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load_alu) begin
            r_alu_o     <= w_res;
            r_flags     <= w_alu_flags;
            r_out_valid <= 1'b1;
        end else if (w_mul_done) begin
            r_alu_o     <= w_mul_res;
            r_flags     <= w_mul_flags;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign alu_o     = r_alu_o;
    assign flags     = r_flags;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       encode_op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_o;
    logic [3:0]       flags;
    logic             out_valid;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a         (a),
        .b         (b),
        .encode_op (encode_op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_o     (alu_o),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
        encode_op = op;
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    initial begin
        reset_n   = 1'b0;
        a         = '0;
        b         = '0;
        encode_op = 3'b000;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_alu_o",     32'(alu_o),     32'h0);
        chk("rst_flags",     32'(flags),     32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'h1);

        // ADD 91+91 = 0x122 -> 22, carry and signed overflow.
        drive(OP_ADD, 8'h91, 8'h91);
        @(negedge clk);
        chk("add_valid", 32'(out_valid), 32'h1);
        chk("add_res",   32'(alu_o),     32'h22);
        chk("add_flags", 32'(flags),     32'hC);
        in_valid = 1'b0;
        @(negedge clk);
        chk("add_drain", 32'(out_valid), 32'h0);

        // Back-to-back SUB then SLL.
        drive(OP_SUB, 8'h1f, 8'h11);
        chk("sub_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        chk("sub_res",      32'(alu_o),    32'h0e);
        chk("sub_flags",    32'(flags),    32'h8);
        chk("sll_in_ready", 32'(in_ready), 32'h1);
        drive(OP_SLL, 8'h11, 8'h01);
        @(negedge clk);
        chk("sll_valid",    32'(out_valid), 32'h1);
        chk("sll_res",      32'(alu_o),     32'h22);
        chk("sll_flags",    32'(flags),     32'h0);
        chk("sll_in_ready2", 32'(in_ready), 32'h1);
        in_valid = 1'b0;
        @(negedge clk);

        // MUL 1f*11 = 0x20F; an ADD held on the input while busy must be ignored.
        drive(OP_MUL, 8'h1f, 8'h11);
        @(negedge clk);
        drive(OP_ADD, 8'hff, 8'hff);
        for (int i = 0; i < 7; i++) begin
            chk("mul_busy_rdy", 32'(in_ready),  32'h0);
            chk("mul_busy_vld", 32'(out_valid), 32'h0);
            @(negedge clk);
        end
        chk("mul_last_rdy", 32'(in_ready),  32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mul_valid",    32'(out_valid), 32'h1);
        chk("mul_res",      32'(alu_o),     32'h0f);
        chk("mul_flags",    32'(flags),     32'hC);
        chk("mul_done_rdy", 32'(in_ready),  32'h1);
        @(negedge clk);
        chk("mul_drain",    32'(out_valid), 32'h0);

        // XOR to zero held under backpressure; second op waits.
        out_ready = 1'b0;
        drive(OP_XOR, 8'h1f, 8'h1f);
        @(negedge clk);
        drive(OP_ADD, 8'h01, 8'h01);
        for (int i = 0; i < 3; i++) begin
            chk("xor_hold_vld", 32'(out_valid), 32'h1);
            chk("xor_hold_res", 32'(alu_o),     32'h00);
            chk("xor_hold_flg", 32'(flags),     32'h1);
            chk("xor_hold_rdy", 32'(in_ready),  32'h0);
            @(negedge clk);
        end
        chk("xor_still_res", 32'(alu_o), 32'h00);
        out_ready = 1'b1;
        #1;
        chk("xor_release_rdy", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("second_valid", 32'(out_valid), 32'h1);
        chk("second_res",   32'(alu_o),     32'h02);
        chk("second_flags", 32'(flags),     32'h0);
        @(negedge clk);
        chk("second_drain", 32'(out_valid), 32'h0);

        // SRL by 0x0c uses only the low 3 bits (4): 0x11 >> 4 = 0x01.
        drive(OP_SRL, 8'h11, 8'h0c);
        @(negedge clk);
        chk("srl_res",   32'(alu_o), 32'h01);
        chk("srl_flags", 32'(flags), 32'h0);

        // SUB with borrow: 10-20 = f0, C=0, N=1.
        drive(OP_SUB, 8'h10, 8'h20);
        @(negedge clk);
        chk("sub_borrow_res",   32'(alu_o), 32'hf0);
        chk("sub_borrow_flags", 32'(flags), 32'h2);

        // MUL by zero: result 0, Z=1, full latency.
        drive(OP_MUL, 8'hff, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("mul0_early_vld", 32'(out_valid), 32'h0);
        @(negedge clk);
        chk("mul0_valid", 32'(out_valid), 32'h1);
        chk("mul0_res",   32'(alu_o),     32'h00);
        chk("mul0_flags", 32'(flags),     32'h1);

        // Shift by zero (b low bits 000): result = a, N=1.
        drive(OP_SLL, 8'h80, 8'h08);
        @(negedge clk);
        in_valid = 1'b0;
        chk("sh0_res",   32'(alu_o), 32'h80);
        chk("sh0_flags", 32'(flags), 32'h2);
        @(negedge clk);

        // Reset in the 4th cycle of a MUL clears outputs and discards the op.
        drive(OP_MUL, 8'h1f, 8'h11);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rstmid_vld",   32'(out_valid), 32'h0);
        chk("rstmid_res",   32'(alu_o),     32'h0);
        chk("rstmid_flags", 32'(flags),     32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rstmid_rdy", 32'(in_ready), 32'h1);
        for (int i = 0; i < 10; i++) begin
            chk("rstmid_no_stale", 32'(out_valid), 32'h0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
